// File: rtl/rx_seq_monitor.sv
// rtl/rx_seq_monitor.sv - receive-side sequence-number monitor with statistics and report stream
//
// Tracks frames delivered by the redundancy voter, extracts a 16-bit sequence
// number at a fixed byte offset, counts accepted/runt frames, sequence gaps and
// voter losses, and emits a 6-byte record per accepted frame on a ready/valid
// byte stream.
//
// Ports:
//   clk125MHz    single clock, rising edge
//   reset        synchronous, active-high
//   en_in        byte valid, high for the whole frame
//   data_in      frame byte
//   loss_in      voter loss event, one count per high cycle
//   clear        synchronous statistics clear
//   rep_ready    report sink ready
//   rep_valid    report byte valid
//   rep_data     report byte
//   seq_err      one-cycle pulse on a sequence gap
//   frame_count  accepted frames (saturating)
//   gap_count    sequence gaps (saturating)
//   loss_count   voter loss events (saturating)
//   runt_count   runt frames (saturating)
//   drop_count   records dropped while a report was in flight (saturating)
//   last_seq     sequence number of the last accepted frame

module rx_seq_monitor #(
  parameter int SEQ_OFFSET = 6'h22,
  parameter int MIN_LEN    = 64
) (
  input  logic        clk125MHz,
  input  logic        reset,
  input  logic        en_in,
  input  logic [7:0]  data_in,
  input  logic        loss_in,
  input  logic        clear,
  input  logic        rep_ready,
  output logic        rep_valid,
  output logic [7:0]  rep_data,
  output logic        seq_err,
  output logic [31:0] frame_count,
  output logic [15:0] gap_count,
  output logic [15:0] loss_count,
  output logic [15:0] runt_count,
  output logic [7:0]  drop_count,
  output logic [15:0] last_seq
);

  localparam logic [10:0] SEQ_MSB_IDX = 11'(SEQ_OFFSET);
  localparam logic [10:0] SEQ_LSB_IDX = 11'(SEQ_OFFSET + 1);
  localparam logic [10:0] IDX_MAX     = 11'h7FF;

  typedef enum logic {IDLE, SEND} rep_state_t;

  // ---------------------------------------------------------------------------
  // Frame tracking
  // ---------------------------------------------------------------------------
  logic        armed;
  logic        in_frame;
  logic [10:0] byte_cnt;   // bytes seen in the current frame, saturating
  logic [10:0] cur_idx;
  logic [15:0] seq_cap;

  // The first byte of a frame is index 0 regardless of the stale count.
  assign cur_idx = in_frame ? byte_cnt : 11'd0;

  always_ff @(posedge clk125MHz) begin
    if (reset) begin
      armed    <= 1'b0;
      in_frame <= 1'b0;
      byte_cnt <= 11'd0;
      seq_cap  <= 16'h0000;
    end else if (!en_in) begin
      // Seeing the line idle is what arms the monitor, so a frame already in
      // progress at reset release is never mistaken for a complete one.
      armed    <= 1'b1;
      in_frame <= 1'b0;
    end else if (armed) begin
      in_frame <= 1'b1;
      byte_cnt <= (cur_idx == IDX_MAX) ? IDX_MAX : cur_idx + 11'd1;
      if (cur_idx == SEQ_MSB_IDX) seq_cap[15:8] <= data_in;
      if (cur_idx == SEQ_LSB_IDX) seq_cap[7:0]  <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-end classification
  // ---------------------------------------------------------------------------
  logic        frame_end;
  logic        is_runt;
  logic        accepted;
  logic        first_frame;
  logic        gap_now;
  logic [15:0] gap_next;
  int          frame_len;
  rep_state_t  state;

  always_comb begin
    frame_len = int'(byte_cnt);
    frame_end = in_frame && !en_in;
    // A frame too short to carry both sequence bytes is a runt even when
    // MIN_LEN would otherwise let it through.
    is_runt   = (frame_len < MIN_LEN) || (frame_len <= SEQ_OFFSET + 1);
    accepted  = frame_end && !is_runt;
    gap_now   = accepted && !first_frame && (seq_cap != last_seq + 16'd1);
    gap_next  = (gap_now && gap_count != 16'hFFFF) ? gap_count + 16'd1 : gap_count;
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk125MHz) begin
    if (reset) begin
      frame_count <= 32'd0;
      gap_count   <= 16'd0;
      loss_count  <= 16'd0;
      runt_count  <= 16'd0;
      drop_count  <= 8'd0;
      last_seq    <= 16'd0;
      first_frame <= 1'b1;
      seq_err     <= 1'b0;
    end else begin
      seq_err <= gap_now;
      if (clear) begin
        frame_count <= 32'd0;
        gap_count   <= 16'd0;
        loss_count  <= 16'd0;
        runt_count  <= 16'd0;
        drop_count  <= 8'd0;
        last_seq    <= 16'd0;
        first_frame <= 1'b1;
      end else begin
        if (loss_in && loss_count != 16'hFFFF)
          loss_count <= loss_count + 16'd1;
        if (frame_end && is_runt && runt_count != 16'hFFFF)
          runt_count <= runt_count + 16'd1;
        if (accepted) begin
          if (frame_count != 32'hFFFF_FFFF)
            frame_count <= frame_count + 32'd1;
          gap_count   <= gap_next;
          last_seq    <= seq_cap;
          first_frame <= 1'b0;
          if (state == SEND && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Report FSM
  // ---------------------------------------------------------------------------
  logic [39:0] rec_tail;   // record bytes 1..5 queued behind rep_data
  logic [2:0]  remain;     // bytes still to send after the one on rep_data

  always_ff @(posedge clk125MHz) begin
    if (reset) begin
      state     <= IDLE;
      rep_valid <= 1'b0;
      rep_data  <= 8'h00;
      rec_tail  <= 40'd0;
      remain    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accepted) begin
            rep_valid <= 1'b1;
            rep_data  <= 8'h55;
            rec_tail  <= {seq_cap, gap_next[7:0], loss_count[7:0], 7'b0, gap_now};
            remain    <= 3'd5;
            state     <= SEND;
          end
        end
        SEND: begin
          if (rep_ready) begin
            if (remain == 3'd0) begin
              rep_valid <= 1'b0;
              rep_data  <= 8'h00;
              state     <= IDLE;
            end else begin
              rep_data <= rec_tail[39:32];
              rec_tail <= {rec_tail[31:0], 8'h00};
              remain   <= remain - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_seq_monitor.sv
// tb/tb_rx_seq_monitor.sv - self-checking bench for rx_seq_monitor

module tb_rx_seq_monitor;

  localparam int OFF  = 34;
  localparam int MINL = 64;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        reset = 1'b1, en_in = 1'b0, loss_in = 1'b0, clear = 1'b0, rep_ready = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        rep_valid, seq_err;
  logic [7:0]  rep_data, drop_count;
  logic [31:0] frame_count;
  logic [15:0] gap_count, loss_count, runt_count, last_seq;

  logic        en2 = 1'b0;
  logic [7:0]  data2 = 8'h00;
  logic        rep_valid2, seq_err2;
  logic [7:0]  rep_data2, drop_count2;
  logic [31:0] frame_count2;
  logic [15:0] gap_count2, loss_count2, runt_count2, last_seq2;

  rx_seq_monitor dut (
    .clk125MHz(clk), .reset(reset), .en_in(en_in), .data_in(data_in),
    .loss_in(loss_in), .clear(clear), .rep_ready(rep_ready),
    .rep_valid(rep_valid), .rep_data(rep_data), .seq_err(seq_err),
    .frame_count(frame_count), .gap_count(gap_count), .loss_count(loss_count),
    .runt_count(runt_count), .drop_count(drop_count), .last_seq(last_seq)
  );

  rx_seq_monitor #(.SEQ_OFFSET(6'h22), .MIN_LEN(0)) dut2 (
    .clk125MHz(clk), .reset(reset), .en_in(en2), .data_in(data2),
    .loss_in(1'b0), .clear(1'b0), .rep_ready(1'b1),
    .rep_valid(rep_valid2), .rep_data(rep_data2), .seq_err(seq_err2),
    .frame_count(frame_count2), .gap_count(gap_count2), .loss_count(loss_count2),
    .runt_count(runt_count2), .drop_count(drop_count2), .last_seq(last_seq2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Frame-level model: bytes of the frame are kept in a queue and the frame is
  // judged as a whole when the line goes idle.
  bit         chk_on = 0;
  bit         m_armed, m_in, m_first, m_serr;
  logic [7:0] fb[$];
  logic [7:0] rq[$];
  longint     m_frames, m_gaps, m_loss, m_runts, m_drops, m_last;

  always @(posedge clk) begin : model
    bit     was_busy, gf;
    longint len, sq;
    if (reset) begin
      m_armed = 0; m_in = 0; m_first = 1; m_serr = 0;
      fb.delete(); rq.delete();
      m_frames = 0; m_gaps = 0; m_loss = 0; m_runts = 0; m_drops = 0; m_last = 0;
      chk_on = 1;
    end else begin
      m_serr   = 0;
      was_busy = (rq.size() != 0);
      if (was_busy && rep_ready) void'(rq.pop_front());
      if (m_in && !en_in) begin
        len = fb.size();
        if (len < MINL || len <= OFF + 1) begin
          m_runts = sat(m_runts, 16'hFFFF);
        end else begin
          sq = {fb[OFF], fb[OFF+1]};
          gf = !m_first && (sq != ((m_last + 1) % 65536));
          m_frames = sat(m_frames, 32'hFFFF_FFFF);
          if (gf) begin
            m_gaps = sat(m_gaps, 16'hFFFF);
            m_serr = 1;
          end
          if (!was_busy) begin
            rq.push_back(8'h55);
            rq.push_back(8'(sq >> 8));
            rq.push_back(8'(sq));
            rq.push_back(8'(m_gaps));
            rq.push_back(8'(m_loss));
            rq.push_back({7'b0, gf});
          end else begin
            m_drops = sat(m_drops, 8'hFF);
          end
          m_last  = sq;
          m_first = 0;
        end
      end
      if (en_in && m_armed) begin
        if (!m_in) fb.delete();
        fb.push_back(data_in);
        m_in = 1;
      end else if (!en_in) begin
        m_in = 0;
        m_armed = 1;
      end
      if (loss_in) m_loss = sat(m_loss, 16'hFFFF);
      if (clear) begin
        m_frames = 0; m_gaps = 0; m_loss = 0; m_runts = 0; m_drops = 0; m_last = 0;
        m_first = 1;
      end
    end
  end

  logic [7:0] cap[$];
  int         serr_pulses = 0;

  always @(negedge clk) begin : compare
    if (chk_on) begin
      chk("frame_count", frame_count, m_frames);
      chk("gap_count", gap_count, m_gaps);
      chk("loss_count", loss_count, m_loss);
      chk("runt_count", runt_count, m_runts);
      chk("drop_count", drop_count, m_drops);
      chk("last_seq", last_seq, m_last);
      chk("seq_err", seq_err, m_serr);
      chk("rep_valid", rep_valid, rq.size() != 0);
      if (rq.size() != 0) chk("rep_data", rep_data, rq[0]);
      if (rep_valid && rep_ready) cap.push_back(rep_data);
      if (seq_err) serr_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    en_in = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [7:0] fbyte(input int k, input logic [15:0] sq);
    if (k == OFF)     return sq[15:8];
    if (k == OFF + 1) return sq[7:0];
    return 8'(k * 7 + 3);
  endfunction

  task automatic send_frame(input int len, input logic [15:0] sq);
    for (int k = 0; k < len; k++) begin
      en_in   = 1'b1;
      data_in = fbyte(k, sq);
      tick();
    end
    en_in   = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic send_frame2(input int len, input logic [15:0] sq);
    for (int k = 0; k < len; k++) begin
      en2   = 1'b1;
      data2 = fbyte(k, sq);
      tick();
    end
    en2   = 1'b0;
    data2 = 8'h00;
    repeat (4) tick();
  endtask

  task automatic chk_rec(input string name, input int base, input logic [47:0] rec);
    if (cap.size() < base + 6) begin
      chk({name, "_len"}, cap.size(), base + 6);
    end else begin
      for (int i = 0; i < 6; i++)
        chk(name, cap[base + i], rec[47 - 8*i -: 8]);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_frame"}, frame_count, 0);
    chk({name, "_gap"}, gap_count, 0);
    chk({name, "_loss"}, loss_count, 0);
    chk({name, "_runt"}, runt_count, 0);
    chk({name, "_drop"}, drop_count, 0);
    chk({name, "_last"}, last_seq, 0);
    chk({name, "_serr"}, seq_err, 0);
    chk({name, "_valid"}, rep_valid, 0);
    chk({name, "_data"}, rep_data, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    idle(3);

    // two in-order frames
    cap.delete();
    serr_pulses = 0;
    send_frame(100, 16'h0001); idle(10);
    send_frame(100, 16'h0002); idle(10);
    chk("two_frames_count", frame_count, 2);
    chk("two_frames_gap", gap_count, 0);
    chk("two_frames_serr", serr_pulses, 0);
    chk("model_frames", m_frames, 2);
    chk("two_frames_bytes", cap.size(), 12);
    chk_rec("rec_seq1", 0, 48'h55_00_01_00_00_00);
    chk_rec("rec_seq2", 6, 48'h55_00_02_00_00_00);

    // sequence gap, then wrap-around
    clear = 1'b1; tick(); clear = 1'b0;
    cap.delete();
    serr_pulses = 0;
    send_frame(100, 16'h0005); idle(10);
    send_frame(100, 16'h0008);
    tick();
    chk("gap_pulse_high", seq_err, 1);
    tick();
    chk("gap_pulse_low", seq_err, 0);
    idle(10);
    chk("gap_count_1", gap_count, 1);
    chk("model_gaps", m_gaps, 1);
    chk("gap_pulses", serr_pulses, 1);
    chk_rec("rec_seq5", 0, 48'h55_00_05_00_00_00);
    chk_rec("rec_seq8", 6, 48'h55_00_08_01_00_01);
    send_frame(100, 16'hFFFF); idle(10);
    chk("gap_to_ffff", gap_count, 2);
    send_frame(100, 16'h0000); idle(10);
    chk("wrap_no_gap", gap_count, 2);
    chk("wrap_last_seq", last_seq, 0);
    chk("wrap_frames", frame_count, 4);

    // runts and length boundaries
    cap.delete();
    send_frame(40, 16'h0100); idle(10);
    chk("runt40_runt", runt_count, 1);
    chk("runt40_frames", frame_count, 4);
    chk("runt40_no_report", cap.size(), 0);
    send_frame(63, 16'h0001); idle(10);
    chk("runt63_runt", runt_count, 2);
    send_frame(64, 16'h0001); idle(10);
    chk("len64_frames", frame_count, 5);
    chk("len64_last", last_seq, 1);
    send_frame2(35, 16'h4321);
    chk("min0_len35_runt", runt_count2, 1);
    chk("min0_len35_frames", frame_count2, 0);
    send_frame2(36, 16'h1234);
    chk("min0_len36_frames", frame_count2, 1);
    chk("min0_len36_last", last_seq2, 16'h1234);

    // back-pressure and dropped record
    clear = 1'b1; tick(); clear = 1'b0;
    rep_ready = 1'b0;
    cap.delete();
    send_frame(100, 16'h0010); idle(2);
    send_frame(100, 16'h0011); idle(5);
    chk("bp_drop", drop_count, 1);
    chk("bp_valid", rep_valid, 1);
    chk("bp_data", rep_data, 8'h55);
    chk("bp_last", last_seq, 16'h0011);
    rep_ready = 1'b1;
    idle(12);
    chk("bp_bytes", cap.size(), 6);
    chk_rec("rec_bp", 0, 48'h55_00_10_00_00_00);

    // reset in the middle of a frame
    for (int k = 0; k < 80; k++) begin
      en_in   = 1'b1;
      data_in = fbyte(k, 16'h0099);
      if (k == 50) reset = 1'b1;
      if (k == 52) reset = 1'b0;
      tick();
      if (k == 51) chk_all_zero("midreset");
    end
    idle(3);
    chk("midreset_tail_ignored", frame_count, 0);
    send_frame(100, 16'h0020); idle(10);
    chk("post_reset_frames", frame_count, 1);
    chk("post_reset_gap", gap_count, 0);
    chk("post_reset_last", last_seq, 16'h0020);

    // loss counting, clear priority, saturation
    loss_in = 1'b1; idle(3); loss_in = 1'b0; tick();
    chk("loss_3", loss_count, 3);
    clear = 1'b1; loss_in = 1'b1; tick(); clear = 1'b0; loss_in = 1'b0;
    chk("loss_clear_wins", loss_count, 0);
    loss_in = 1'b1; idle(70000); loss_in = 1'b0; tick();
    chk("loss_saturated", loss_count, 16'hFFFF);

    chk("dut2_gap", gap_count2, 0);
    chk("dut2_loss", loss_count2, 0);
    chk("dut2_drop", drop_count2, 0);
    chk("dut2_valid", rep_valid2, 0);
    chk("dut2_data", rep_data2, 0);
    chk("dut2_serr", seq_err2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
